// File: rtl/alu_bist_ctrl_if.sv
// Control/status bundle between the ALU BIST controller, its LFSR/ALU/MISR datapath and the host.
interface alu_bist_ctrl_if #(
  parameter int WIDTH = 24
);
  logic             start_i;
  logic             abort_i;
  logic [WIDTH-1:0] golden_i;
  logic [WIDTH-1:0] signature_i;
  logic             misr_clr_o;
  logic             load_o;
  logic             lfsr_adv_o;
  logic             misr_en_o;
  logic [3:0]       cntrl_alu_o;
  logic [15:0]      pattern_o;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;

  modport master (
    output start_i, abort_i, golden_i, signature_i,
    input  misr_clr_o, load_o, lfsr_adv_o, misr_en_o, cntrl_alu_o, pattern_o,
    input  busy_o, done_o, pass_o
  );

  modport slave (
    input  start_i, abort_i, golden_i, signature_i,
    output misr_clr_o, load_o, lfsr_adv_o, misr_en_o, cntrl_alu_o, pattern_o,
    output busy_o, done_o, pass_o
  );
endinterface

// File: rtl/alu_bist_ctrl.sv
// ALU built-in self-test sequencer: clears the MISR, steps LFSR operands through every op, checks signature.
// Optional macro ALU_BIST_AUTORUN_EN: treat the first edge after reset release as an accepted start.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | MISR clear strobe, counters zeroed
// LOAD    | capture LFSR operands into reg_a/reg_b and step the LFSRs
// CAPTURE | one ALU op per cycle compacted into the MISR
// COMPARE | register signature == golden
// DONE    | hold done/pass until start, abort or reset
module alu_bist_ctrl #(
  parameter int WIDTH    = 24,
  parameter int PATTERNS = 16,
  parameter int OP_COUNT = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_bist_ctrl_if.slave bist
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_CAPTURE = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0]  OP_LAST  = 4'(OP_COUNT - 1);
  localparam logic [15:0] PAT_LAST = 16'(PATTERNS - 1);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] pat_q, pat_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        start_req;
  logic        busy;

`ifdef ALU_BIST_AUTORUN_EN
  logic auto_q, auto_d;

  // Pending autorun is armed by reset and consumed on the very first edge after release.
  always_comb begin
    auto_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= auto_d;
    end
  end

  assign start_req = bist.start_i | auto_q;
`else
  assign start_req = bist.start_i;
`endif

  assign busy = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                (state_q == S_CAPTURE) || (state_q == S_COMPARE);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      pat_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pat_d   = pat_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bist.abort_i) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (start_req) begin
          state_d = S_CLEAR;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      S_CLEAR: begin
        op_d    = '0;
        pat_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        op_d    = '0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (op_q == OP_LAST) begin
          op_d = '0;
          if (pat_q == PAT_LAST) begin
            state_d = S_COMPARE;
          end else begin
            pat_d   = pat_q + 16'd1;
            state_d = S_LOAD;
          end
        end else begin
          op_d = op_q + 4'd1;
        end
      end
      S_COMPARE: begin
        pass_d  = (bist.signature_i[WIDTH-1:0] == bist.golden_i[WIDTH-1:0]);
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        op_d    = '0;
        pat_d   = '0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    endcase

    // Abort overrides whatever the busy state would have done this edge.
    if (busy && bist.abort_i) begin
      state_d = S_IDLE;
      op_d    = '0;
      pat_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end

  always_comb begin
    bist.misr_clr_o  = (state_q == S_CLEAR);
    bist.load_o      = (state_q == S_LOAD);
    bist.lfsr_adv_o  = (state_q == S_LOAD);
    bist.misr_en_o   = (state_q == S_CAPTURE);
    bist.cntrl_alu_o = (state_q == S_CAPTURE) ? op_q : 4'd0;
    bist.pattern_o   = pat_q;
    bist.busy_o      = busy;
    bist.done_o      = done_q;
    bist.pass_o      = pass_q;
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl with a behavioural LFSR/ALU/MISR datapath around it.
module tb_alu_bist_ctrl;
  localparam int WIDTH     = 24;
  localparam int PATTERNS  = 4;
  localparam int OP_COUNT  = 15;
  localparam int RUN_EDGES = 2 + PATTERNS * (1 + OP_COUNT);
  localparam logic [WIDTH-1:0] SEED_A = 24'h5A5A5A;
  localparam logic [WIDTH-1:0] SEED_B = 24'hC3C3C3;
  localparam logic [WIDTH-1:0] POLY   = 24'h00001B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_bist_ctrl_if #(.WIDTH(WIDTH)) bif ();

  alu_bist_ctrl #(.WIDTH(WIDTH), .PATTERNS(PATTERNS), .OP_COUNT(OP_COUNT)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bist (bif)
  );

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], 1'b0} ^ (x[WIDTH-1] ? POLY : '0);
  endfunction

  function automatic logic [WIDTH-1:0] alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << 1;
      4'd7:    return a >> 1;
      4'd8:    return b - a;
      4'd9:    return a + 1;
      4'd10:   return ~(a & b);
      4'd11:   return ~(a | b);
      4'd12:   return a ^ ~b;
      4'd13:   return {a[WIDTH-2:0], a[WIDTH-1]};
      4'd14:   return b;
      default: return a;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] misr(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] r);
    return lfsr_step(s) ^ r;
  endfunction

  function automatic logic [WIDTH-1:0] model_sig();
    logic [WIDTH-1:0] la, lb, ra, rb, s;
    la = SEED_A; lb = SEED_B; s = '0;
    for (int p = 0; p < PATTERNS; p++) begin
      ra = la; rb = lb;
      la = lfsr_step(la); lb = lfsr_step(lb);
      for (int op = 0; op < OP_COUNT; op++) s = misr(s, alu(4'(op), ra, rb));
    end
    return s;
  endfunction

  // Datapath environment driven purely by the controller strobes.
  logic [WIDTH-1:0] lfsr_a, lfsr_b, reg_a, reg_b, sig;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_a <= SEED_A; lfsr_b <= SEED_B; reg_a <= '0; reg_b <= '0; sig <= '0;
    end else begin
      if (bif.misr_clr_o) begin
        sig <= '0; lfsr_a <= SEED_A; lfsr_b <= SEED_B;
      end
      if (bif.lfsr_adv_o) begin
        lfsr_a <= lfsr_step(lfsr_a); lfsr_b <= lfsr_step(lfsr_b);
      end
      if (bif.load_o) begin
        reg_a <= lfsr_a; reg_b <= lfsr_b;
      end
      if (bif.misr_en_o) sig <= misr(sig, alu(bif.cntrl_alu_o, reg_a, reg_b));
    end
  end
  assign bif.signature_i = sig;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_sig;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-run protocol monitor.
  bit mon_on = 1'b0;
  int n_load, n_en, n_clr, seq_err, op_exp, pat_exp;
  always @(negedge clk) begin
    if (mon_on) begin
      if (bif.misr_clr_o) n_clr++;
      if (bif.load_o != bif.lfsr_adv_o) seq_err++;
      if (bif.load_o) n_load++;
      if (bif.misr_en_o) begin
        n_en++;
        if (bif.cntrl_alu_o != 4'(op_exp) || bif.pattern_o != 16'(pat_exp)) seq_err++;
        if (op_exp == OP_COUNT - 1) begin op_exp = 0; pat_exp++; end
        else op_exp++;
      end else if (bif.cntrl_alu_o != 4'd0) seq_err++;
    end
  end

  typedef struct {
    bit exp_pass;
    int exp_edge;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [WIDTH-1:0] flip;
    bit               hold_start;
    bit               exp_pass;
  } vec_t;
  vec_t vecs[5];

  task automatic arm(input logic [WIDTH-1:0] flip, input bit exp_pass);
    sb_t e;
    n_load = 0; n_en = 0; n_clr = 0; seq_err = 0; op_exp = 0; pat_exp = 0;
    bif.golden_i = exp_sig ^ flip;
    e.exp_pass = exp_pass;
    e.exp_edge = RUN_EDGES;
    sb_q.push_back(e);
    mon_on = 1'b1;
  endtask

  // Called at the falling edge right after the start-sampling edge.
  task automatic observe(input string tag);
    int n;
    sb_t e;
    check({tag, " busy_after_start"}, 32'(bif.busy_o), 32'd1);
    check({tag, " clr_after_start"}, 32'(bif.misr_clr_o), 32'd1);
    check({tag, " done_cleared"}, 32'({bif.done_o, bif.pass_o}), 32'd0);
    n = 0;
    while (!bif.done_o && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bif.start_i = 1'b0;
    e = sb_q.pop_front();
    check({tag, " done_edge"}, 32'(n), 32'(e.exp_edge));
    check({tag, " pass"}, 32'(bif.pass_o), 32'(e.exp_pass));
    check({tag, " load_pulses"}, 32'(n_load), 32'(PATTERNS));
    check({tag, " misr_en_cycles"}, 32'(n_en), 32'(PATTERNS * OP_COUNT));
    check({tag, " single_clear"}, 32'(n_clr), 32'd1);
    check({tag, " op_sequence_errs"}, 32'(seq_err), 32'd0);
    check({tag, " signature"}, 32'(sig), 32'(exp_sig));
    check({tag, " busy_in_done"}, 32'(bif.busy_o), 32'd0);
    mon_on = 1'b0;
  endtask

  task automatic run_one(input logic [WIDTH-1:0] flip, input bit hold, input bit exp_pass,
                         input string tag);
    arm(flip, exp_pass);
    bif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) bif.start_i = 1'b0;
    observe(tag);
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef ALU_BIST_AUTORUN_EN
    arm('0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    observe({tag, " autorun"});
`else
    @(posedge clk);
    @(negedge clk);
    check({tag, " no_autostart_busy"}, 32'(bif.busy_o), 32'd0);
    check({tag, " no_autostart_clr"}, 32'(bif.misr_clr_o), 32'd0);
`endif
  endtask

  function automatic logic [31:0] strobes();
    return {20'd0, bif.cntrl_alu_o, bif.busy_o, bif.done_o, bif.pass_o, bif.misr_clr_o,
            bif.load_o, bif.lfsr_adv_o, bif.misr_en_o, 1'b0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.start_i = 1'b0;
    bif.abort_i = 1'b0;
    exp_sig = model_sig();
    bif.golden_i = exp_sig;

    vecs[0] = '{flip: '0,           hold_start: 1'b0, exp_pass: 1'b1};
    vecs[1] = '{flip: 24'h000001,   hold_start: 1'b0, exp_pass: 1'b0};
    vecs[2] = '{flip: '0,           hold_start: 1'b1, exp_pass: 1'b1};
    vecs[3] = '{flip: 24'h800000,   hold_start: 1'b0, exp_pass: 1'b0};
    vecs[4] = '{flip: '0,           hold_start: 1'b0, exp_pass: 1'b1};

    #22;
    check("reset strobes", strobes(), 32'd0);
    check("reset pattern", 32'(bif.pattern_o), 32'd0);
    release_reset("init");

    // Back-to-back runs: each later run starts from DONE.
    for (int i = 0; i < 5; i++)
      run_one(vecs[i].flip, vecs[i].hold_start, vecs[i].exp_pass, $sformatf("vec%0d", i));

    // Abort while in DONE.
    bif.abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.abort_i = 1'b0;
    check("abort_in_done", strobes(), 32'd0);

    // Abort has priority over a simultaneous start.
    bif.start_i = 1'b1;
    bif.abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start_i = 1'b0;
    bif.abort_i = 1'b0;
    check("abort_beats_start", strobes(), 32'd0);

    // Abort mid-CAPTURE at edge 10 of the run.
    bif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_abort_capture", 32'(bif.misr_en_o), 32'd1);
    bif.abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.abort_i = 1'b0;
    check("abort_edge10", strobes(), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_stays_idle", strobes(), 32'd0);

    // Asynchronous reset between edges in the middle of CAPTURE.
    bif.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start_i = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset strobes", strobes(), 32'd0);
    check("async_reset pattern", 32'(bif.pattern_o), 32'd0);
    release_reset("midrun");
    run_one('0, 1'b0, 1'b1, "rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
